// File: rtl/control_unit.sv
// control_unit: opcode decoder and sequencer for the vector ASIP datapath.
// Single-cycle instructions complete in the decode state. Vector ALU and
// vector memory instructions latch their opcode and hold the decoded controls
// until the matching completion input is seen. Finished pulses once per
// instruction so that fetch can advance the PC.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] OpCode,
  input  logic       Mem_Finished,
  input  logic       Exe_Finished,
  output logic       RegFileWE,
  output logic       ExtendSelect,
  output logic       ALUSource,
  output logic       MemWE,
  output logic       WBSelect,
  output logic       Finished,
  output logic [1:0] BranchSelect,
  output logic [1:0] OpType,
  output logic [1:0] ALUControl
);

  // Opcode map
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_VADD = 4'd4;
  localparam logic [3:0] OP_VSUB = 4'd5;
  localparam logic [3:0] OP_VMUL = 4'd6;
  localparam logic [3:0] OP_VXOR = 4'd7;
  localparam logic [3:0] OP_VLD  = 4'd8;
  localparam logic [3:0] OP_VST  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_BEQZ = 4'd11;
  localparam logic [3:0] OP_BNEZ = 4'd12;

  // Instruction classes carried on OpType
  localparam logic [1:0] T_SCALAR = 2'b00;
  localparam logic [1:0] T_VALU   = 2'b01;
  localparam logic [1:0] T_VMEM   = 2'b10;
  localparam logic [1:0] T_CTRL   = 2'b11;

  // Branch selections
  localparam logic [1:0] BR_PC1  = 2'b00;
  localparam logic [1:0] BR_JMP  = 2'b01;
  localparam logic [1:0] BR_BEQZ = 2'b10;
  localparam logic [1:0] BR_BNEZ = 2'b11;

  // ALU operations
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  typedef enum logic [1:0] {
    S_DECODE = 2'd0,
    S_EXE    = 2'd1,
    S_MEM    = 2'd2
  } state_t;

  typedef struct packed {
    logic       reg_we;
    logic       ext_sel;
    logic       alu_src;
    logic       mem_we;
    logic       wb_sel;
    logic [1:0] br_sel;
    logic [1:0] op_type;
    logic [1:0] alu_ctl;
  } ctrl_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] op_q;
  logic [3:0] op_next;
  ctrl_t      ctrl;
  logic       finished;

  // Raw control fields for one opcode; reserved codes decode as NOP.
  function automatic ctrl_t decode_op(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD: begin
        c.reg_we  = 1'b1;
        c.op_type = T_SCALAR;
        c.alu_ctl = ALU_ADD;
      end
      OP_SUB: begin
        c.reg_we  = 1'b1;
        c.op_type = T_SCALAR;
        c.alu_ctl = ALU_SUB;
      end
      OP_ADDI: begin
        c.reg_we  = 1'b1;
        c.alu_src = 1'b1;
        c.op_type = T_SCALAR;
        c.alu_ctl = ALU_ADD;
      end
      OP_VADD: begin
        c.reg_we  = 1'b1;
        c.op_type = T_VALU;
        c.alu_ctl = ALU_ADD;
      end
      OP_VSUB: begin
        c.reg_we  = 1'b1;
        c.op_type = T_VALU;
        c.alu_ctl = ALU_SUB;
      end
      OP_VMUL: begin
        c.reg_we  = 1'b1;
        c.op_type = T_VALU;
        c.alu_ctl = ALU_MUL;
      end
      OP_VXOR: begin
        c.reg_we  = 1'b1;
        c.op_type = T_VALU;
        c.alu_ctl = ALU_XOR;
      end
      OP_VLD: begin
        c.reg_we  = 1'b1;
        c.alu_src = 1'b1;
        c.wb_sel  = 1'b1;
        c.op_type = T_VMEM;
        c.alu_ctl = ALU_ADD;
      end
      OP_VST: begin
        c.alu_src = 1'b1;
        c.mem_we  = 1'b1;
        c.op_type = T_VMEM;
        c.alu_ctl = ALU_ADD;
      end
      OP_JMP: begin
        c.ext_sel = 1'b1;
        c.br_sel  = BR_JMP;
        c.op_type = T_CTRL;
        c.alu_ctl = ALU_ADD;
      end
      OP_BEQZ: begin
        c.ext_sel = 1'b1;
        c.br_sel  = BR_BEQZ;
        c.op_type = T_CTRL;
        c.alu_ctl = ALU_SUB;
      end
      OP_BNEZ: begin
        c.ext_sel = 1'b1;
        c.br_sel  = BR_BNEZ;
        c.op_type = T_CTRL;
        c.alu_ctl = ALU_SUB;
      end
      default: begin
        c         = '0;
        c.br_sel  = BR_PC1;
      end
    endcase
    return c;
  endfunction

  // State and latched opcode; reset returns to decode with op_q cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_DECODE;
      op_q  <= OP_NOP;
    end else begin
      state <= state_next;
      op_q  <= op_next;
    end
  end

  // Next state and outputs; the finish inputs are only looked at in their own wait state.
  always_comb begin
    state_next = state;
    op_next    = op_q;
    ctrl       = '0;
    finished   = 1'b0;
    case (state)
      S_DECODE: begin
        ctrl = decode_op(OpCode);
        case (ctrl.op_type)
          T_VALU: begin
            ctrl.reg_we = 1'b0;
            op_next     = OpCode;
            state_next  = S_EXE;
          end
          T_VMEM: begin
            ctrl.reg_we = 1'b0;
            ctrl.mem_we = 1'b0;
            op_next     = OpCode;
            state_next  = S_MEM;
          end
          default: begin
            finished = 1'b1;
          end
        endcase
      end
      S_EXE: begin
        ctrl        = decode_op(op_q);
        ctrl.reg_we = Exe_Finished;
        finished    = Exe_Finished;
        if (Exe_Finished) begin
          state_next = S_DECODE;
        end
      end
      S_MEM: begin
        ctrl        = decode_op(op_q);
        ctrl.reg_we = ctrl.reg_we & Mem_Finished;
        finished    = Mem_Finished;
        if (Mem_Finished) begin
          state_next = S_DECODE;
        end
      end
      default: begin
        state_next = S_DECODE;
      end
    endcase
  end

  // Output drive; everything is held at zero while reset is asserted.
  always_comb begin
    RegFileWE    = 1'b0;
    ExtendSelect = 1'b0;
    ALUSource    = 1'b0;
    MemWE        = 1'b0;
    WBSelect     = 1'b0;
    Finished     = 1'b0;
    BranchSelect = 2'b00;
    OpType       = 2'b00;
    ALUControl   = 2'b00;
    if (rst_n) begin
      RegFileWE    = ctrl.reg_we;
      ExtendSelect = ctrl.ext_sel;
      ALUSource    = ctrl.alu_src;
      MemWE        = ctrl.mem_we;
      WBSelect     = ctrl.wb_sel;
      Finished     = finished;
      BranchSelect = ctrl.br_sel;
      OpType       = ctrl.op_type;
      ALUControl   = ctrl.alu_ctl;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table vectors, hand sequences and random stimulus checked
// against an instruction-level reference model of control_unit.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] OpCode = 4'd0;
  logic       Mem_Finished = 1'b0;
  logic       Exe_Finished = 1'b0;
  logic       RegFileWE, ExtendSelect, ALUSource, MemWE, WBSelect, Finished;
  logic [1:0] BranchSelect, OpType, ALUControl;

  int tests = 0;
  int fails = 0;
  // Opcode of the instruction still waiting for completion, -1 when idle.
  int pending = -1;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode),
    .Mem_Finished(Mem_Finished), .Exe_Finished(Exe_Finished),
    .RegFileWE(RegFileWE), .ExtendSelect(ExtendSelect), .ALUSource(ALUSource),
    .MemWE(MemWE), .WBSelect(WBSelect), .Finished(Finished),
    .BranchSelect(BranchSelect), .OpType(OpType), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  // {RegWE,Ext,ASrc,MemWE,WB,Finished,Br[1:0],OpT[1:0],ALU[1:0]}
  wire [11:0] outs = {RegFileWE, ExtendSelect, ALUSource, MemWE, WBSelect, Finished,
                      BranchSelect, OpType, ALUControl};

  // Opcode table: {RegWE,Ext,ASrc,MemWE,WB,Br,OpT,ALU}
  function automatic logic [10:0] table_fields(input int op);
    case (op)
      1:  return 11'b10000_00_00_00;
      2:  return 11'b10000_00_00_01;
      3:  return 11'b10100_00_00_00;
      4:  return 11'b10000_00_01_00;
      5:  return 11'b10000_00_01_01;
      6:  return 11'b10000_00_01_10;
      7:  return 11'b10000_00_01_11;
      8:  return 11'b10101_00_10_00;
      9:  return 11'b00110_00_10_00;
      10: return 11'b01000_01_11_00;
      11: return 11'b01000_10_11_01;
      12: return 11'b01000_11_11_01;
      default: return 11'b0;
    endcase
  endfunction

  function automatic logic [11:0] model_out();
    logic [10:0] f;
    logic reg_we, mem_we, fin, done;
    if (!rst_n) return 12'b0;
    f = table_fields(pending < 0 ? int'(OpCode) : pending);
    reg_we = f[10];
    mem_we = f[7];
    if (pending < 0) begin
      if (f[3:2] == 2'b01) begin
        reg_we = 1'b0; fin = 1'b0;
      end else if (f[3:2] == 2'b10) begin
        reg_we = 1'b0; mem_we = 1'b0; fin = 1'b0;
      end else begin
        fin = 1'b1;
      end
    end else begin
      done = (f[3:2] == 2'b01) ? Exe_Finished : Mem_Finished;
      fin = done;
      reg_we = (f[3:2] == 2'b01) ? done : (f[10] & done);
    end
    return {reg_we, f[9:8], mem_we, f[6], fin, f[5:0]};
  endfunction

  // Advance the instruction-level model by one clock.
  task automatic model_step();
    logic [10:0] f;
    if (!rst_n) begin
      pending = -1;
    end else if (pending < 0) begin
      f = table_fields(int'(OpCode));
      if (f[3:2] == 2'b01 || f[3:2] == 2'b10) pending = int'(OpCode);
    end else begin
      f = table_fields(pending);
      if ((f[3:2] == 2'b01) ? Exe_Finished : Mem_Finished) pending = -1;
    end
  endtask

  task automatic check(input string name, input logic [11:0] exp);
    tests++;
    if (outs !== exp) begin
      fails++;
      $display("FAIL %s: outputs %b, required %b", name, outs, exp);
    end
  endtask

  // One clock: drive at negedge, compare 1ns later, advance model at posedge.
  task automatic cyc_core(input logic rst, input logic [3:0] op, input logic mf, input logic ef,
                          input string name, input bit use_const, input logic [11:0] c);
    @(negedge clk);
    rst_n = rst; OpCode = op; Mem_Finished = mf; Exe_Finished = ef;
    if (!rst) pending = -1;
    #1;
    check(name, use_const ? c : model_out());
    @(posedge clk);
    model_step();
  endtask

  task automatic cyc(input logic rst, input logic [3:0] op, input logic mf, input logic ef,
                     input string name);
    cyc_core(rst, op, mf, ef, name, 1'b0, 12'b0);
  endtask

  task automatic cycx(input logic rst, input logic [3:0] op, input logic mf, input logic ef,
                      input string name, input logic [11:0] c);
    cyc_core(rst, op, mf, ef, name, 1'b1, c);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        mf;
    logic        ef;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Table: single-cycle sweep plus first/last cycles of each multi-cycle class.
    vecs.push_back('{4'd0,  1'b0, 1'b0, 12'b000001_00_00_00});
    vecs.push_back('{4'd1,  1'b1, 1'b1, 12'b100001_00_00_00});
    vecs.push_back('{4'd2,  1'b0, 1'b0, 12'b100001_00_00_01});
    vecs.push_back('{4'd3,  1'b0, 1'b0, 12'b101001_00_00_00});
    vecs.push_back('{4'd10, 1'b0, 1'b0, 12'b010001_01_11_00});
    vecs.push_back('{4'd11, 1'b0, 1'b0, 12'b010001_10_11_01});
    vecs.push_back('{4'd12, 1'b0, 1'b0, 12'b010001_11_11_01});
    vecs.push_back('{4'd13, 1'b0, 1'b0, 12'b000001_00_00_00});
    vecs.push_back('{4'd14, 1'b1, 1'b0, 12'b000001_00_00_00});
    vecs.push_back('{4'd15, 1'b0, 1'b1, 12'b000001_00_00_00});
    vecs.push_back('{4'd4,  1'b0, 1'b1, 12'b000000_00_01_00});
    vecs.push_back('{4'd15, 1'b0, 1'b1, 12'b100001_00_01_00});
    vecs.push_back('{4'd5,  1'b0, 1'b0, 12'b000000_00_01_01});
    vecs.push_back('{4'd0,  1'b0, 1'b1, 12'b100001_00_01_01});
    vecs.push_back('{4'd7,  1'b0, 1'b0, 12'b000000_00_01_11});
    vecs.push_back('{4'd0,  1'b0, 1'b1, 12'b100001_00_01_11});
    vecs.push_back('{4'd8,  1'b1, 1'b0, 12'b001010_00_10_00});
    vecs.push_back('{4'd1,  1'b1, 1'b0, 12'b101011_00_10_00});
    vecs.push_back('{4'd9,  1'b0, 1'b0, 12'b001000_00_10_00});
    vecs.push_back('{4'd1,  1'b1, 1'b0, 12'b001101_00_10_00});

    // Reset with ADD on the bus, then release.
    OpCode = 4'd1;
    #1;
    check("reset_outputs", 12'b0);
    cycx(1'b0, 4'd1, 1'b0, 1'b0, "reset_held", 12'b0);
    cycx(1'b1, 4'd1, 1'b0, 1'b0, "release_add", 12'b100001_00_00_00);

    foreach (vecs[i]) begin
      cycx(1'b1, vecs[i].op, vecs[i].mf, vecs[i].ef, $sformatf("vec%0d_op%0d", i, vecs[i].op),
           vecs[i].exp);
    end

    // VMUL waiting three cycles on Exe_Finished, Mem_Finished ignored.
    cycx(1'b1, 4'd6, 1'b0, 1'b0, "vmul_issue", 12'b000000_00_01_10);
    for (int i = 0; i < 3; i++)
      cycx(1'b1, 4'd2, (i == 1), 1'b0, "vmul_wait", 12'b000000_00_01_10);
    cycx(1'b1, 4'd2, 1'b1, 1'b1, "vmul_done", 12'b100001_00_01_10);
    cycx(1'b1, 4'd2, 1'b0, 1'b0, "after_vmul_sub", 12'b100001_00_00_01);

    // VST with OpCode changed while waiting.
    cycx(1'b1, 4'd9, 1'b0, 1'b0, "vst_issue", 12'b001000_00_10_00);
    for (int i = 0; i < 3; i++)
      cycx(1'b1, 4'd1, 1'b0, (i == 0), "vst_wait", 12'b001100_00_10_00);
    cycx(1'b1, 4'd1, 1'b1, 1'b0, "vst_done", 12'b001101_00_10_00);
    cycx(1'b1, 4'd1, 1'b0, 1'b0, "after_vst_add", 12'b100001_00_00_00);

    // VLD ignores Exe_Finished, completes on Mem_Finished.
    cycx(1'b1, 4'd8, 1'b0, 1'b0, "vld_issue", 12'b001010_00_10_00);
    cycx(1'b1, 4'd8, 1'b0, 1'b1, "vld_exe_ignored", 12'b001010_00_10_00);
    cycx(1'b1, 4'd8, 1'b1, 1'b1, "vld_done", 12'b101011_00_10_00);

    // Asynchronous reset in the middle of a vector op.
    cycx(1'b1, 4'd6, 1'b0, 1'b0, "vmul2_issue", 12'b000000_00_01_10);
    cycx(1'b1, 4'd6, 1'b0, 1'b0, "vmul2_wait", 12'b000000_00_01_10);
    @(negedge clk);
    Exe_Finished = 1'b1;
    #2;
    rst_n = 1'b0;
    pending = -1;
    #1;
    check("midop_reset_outputs", 12'b0);
    cycx(1'b0, 4'd6, 1'b0, 1'b1, "midop_reset_held", 12'b0);
    cycx(1'b1, 4'd4, 1'b0, 1'b1, "post_reset_decode", 12'b000000_00_01_00);
    cycx(1'b1, 4'd0, 1'b0, 1'b1, "post_reset_vadd_done", 12'b100001_00_01_00);

    // Random stimulus against the reference model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
